// File: rtl/bank_pkg.sv
// Shared constants and helpers for the parametrised register bank.
// Default geometry, clog2, and the pending-counter step rules.
package bank_pkg;

  localparam int DEF_DW    = 32;
  localparam int DEF_DEPTH = 32;
  localparam int DEF_NR    = 2;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // A reserve only adds to the count when the target was idle.
  function automatic logic pend_inc(
    input logic iss_ok,
    input logic p_iss
  );
    return iss_ok && !p_iss;
  endfunction

  // A write only retires a reservation when no new one lands on
  // the same register in the same cycle.
  function automatic logic pend_dec(
    input logic wr_ok,
    input logic p_dir,
    input logic same
  );
    return wr_ok && p_dir && !same;
  endfunction

endpackage

// File: rtl/bank_reg_param_if.sv
// Register bank bus: write port, NR read ports, reserve port.
// master drives addresses/data/reserve; slave returns L, Busy, Pend.
interface bank_reg_param_if
  import bank_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = 5,
  parameter int NR = DEF_NR
);

  logic             Rw;
  logic [AW-1:0]    Dir;
  logic [DW-1:0]    DIn;
  logic [NR*AW-1:0] Rd;
  logic [NR*DW-1:0] L;
  logic             Iss;
  logic [AW-1:0]    IssDir;
  logic [NR-1:0]    Busy;
  logic [AW:0]      Pend;

  modport master (
    output Rw, Dir, DIn, Rd, Iss, IssDir,
    input  L, Busy, Pend
  );

  modport slave (
    input  Rw, Dir, DIn, Rd, Iss, IssDir,
    output L, Busy, Pend
  );

endinterface

// File: rtl/bank_scoreboard.sv
// Pending-write scoreboard: per-register pending bits and their count.
// Ports: clk, rst, Rw/Dir (write), Iss/IssDir (reserve), p, pend.
module bank_scoreboard
  import bank_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int AW      = clog2(DEPTH),
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Rw,
  input  logic [AW-1:0]    Dir,
  input  logic             Iss,
  input  logic [AW-1:0]    IssDir,
  output logic [DEPTH-1:0] p,
  output logic [AW:0]      pend
);

  logic             wr_ok;
  logic             iss_ok;
  logic             same;
  logic             inc;
  logic             dec;
  logic [DEPTH-1:0] p_next;

  assign wr_ok  = Rw  && !(ZERO_R0 && Dir == '0);
  assign iss_ok = Iss && !(ZERO_R0 && IssDir == '0);
  assign same   = iss_ok && (IssDir == Dir);
  assign inc    = pend_inc(iss_ok, p[IssDir]);
  assign dec    = pend_dec(wr_ok, p[Dir], same);

  // Reserve is applied after the clear so it wins on a clash.
  always_comb begin
    p_next = p;
    if (wr_ok)  p_next[Dir]    = 1'b0;
    if (iss_ok) p_next[IssDir] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p    <= '0;
      pend <= '0;
    end else begin
      p <= p_next;
      case ({inc, dec})
        2'b10:   pend <= pend + (AW+1)'(1);
        2'b01:   pend <= pend - (AW+1)'(1);
        default: pend <= pend;
      endcase
    end
  end

endmodule

// File: rtl/bank_reg_param.sv
// Parametrised register bank with write bypass and hazard scoreboard.
// Ports: clk, rst (sync, active-high), bus (bank_reg_param_if.slave).
module bank_reg_param
  import bank_pkg::*;
#(
  parameter int DW      = DEF_DW,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int AW      = clog2(DEPTH),
  parameter int NR      = DEF_NR,
  parameter bit ZERO_R0 = 1'b1,
  parameter bit BYPASS  = 1'b1
) (
  input logic             clk,
  input logic             rst,
  bank_reg_param_if.slave bus
);

  logic [DW-1:0]    mem [DEPTH];
  logic [DEPTH-1:0] p;
  logic [AW:0]      pend;
  logic             wr_ok;
  logic [NR*DW-1:0] l_all;
  logic [NR-1:0]    b_all;

  assign wr_ok = bus.Rw && !(ZERO_R0 && bus.Dir == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[bus.Dir] <= bus.DIn;
    end
  end

  bank_scoreboard #(
    .DEPTH  (DEPTH),
    .AW     (AW),
    .ZERO_R0(ZERO_R0)
  ) u_sb (
    .clk   (clk),
    .rst   (rst),
    .Rw    (bus.Rw),
    .Dir   (bus.Dir),
    .Iss   (bus.Iss),
    .IssDir(bus.IssDir),
    .p     (p),
    .pend  (pend)
  );

  for (genvar i = 0; i < NR; i++) begin : g_rd
    logic [AW-1:0] ra;
    logic [DW-1:0] l;
    logic          b;

    assign ra = bus.Rd[i*AW +: AW];

    // A bypassed read hides the retiring reservation, unless the
    // same register is re-reserved this cycle.
    always_comb begin
      l = mem[ra];
      b = p[ra];
      if (ZERO_R0 && ra == '0) begin
        l = '0;
        b = 1'b0;
      end else if (BYPASS && bus.Rw && bus.Dir == ra) begin
        l = bus.DIn;
        b = (bus.Iss && bus.IssDir == ra) ? p[ra] : 1'b0;
      end
    end

    assign l_all[i*DW +: DW] = l;
    assign b_all[i]          = b;
  end

  assign bus.L    = l_all;
  assign bus.Busy = b_all;
  assign bus.Pend = pend;

endmodule

// File: tb/tb_bank_reg_param.sv
// Bench: bypass and non-bypass banks driven in lockstep against a model.
// Literal checks pin the directed scenarios; a compare process checks all.
module tb_bank_reg_param;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic clk = 1'b0;
  logic rst;
  logic rw, iss, live;
  logic [AW-1:0] dir, issdir;
  logic [DW-1:0] din;
  logic [NR*AW-1:0] rd;

  int n_pass = 0;
  int n_tot  = 0;

  logic [DW-1:0] m_reg [32];
  logic [31:0]   m_p;

  always #5 clk = ~clk;

  bank_reg_param_if #(.DW(DW), .AW(AW), .NR(NR)) b1 ();
  bank_reg_param_if #(.DW(DW), .AW(AW), .NR(NR)) b0 ();

  assign b1.Rw = rw;   assign b0.Rw = rw;
  assign b1.Dir = dir; assign b0.Dir = dir;
  assign b1.DIn = din; assign b0.DIn = din;
  assign b1.Rd = rd;   assign b0.Rd = rd;
  assign b1.Iss = iss; assign b0.Iss = iss;
  assign b1.IssDir = issdir;
  assign b0.IssDir = issdir;

  bank_reg_param #(
    .DW(DW), .DEPTH(32), .NR(NR), .ZERO_R0(1'b1), .BYPASS(1'b1)
  ) u1 (
    .clk(clk), .rst(rst), .bus(b1)
  );

  bank_reg_param #(
    .DW(DW), .DEPTH(32), .NR(NR), .ZERO_R0(1'b1), .BYPASS(1'b0)
  ) u0 (
    .clk(clk), .rst(rst), .bus(b0)
  );

  task automatic chk(
    input string nm,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  // Model state: register contents and pending set.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) m_reg[i] <= '0;
      m_p <= '0;
    end else begin
      if (rw && dir != 0) begin
        m_reg[dir] <= din;
        m_p[dir]   <= 1'b0;
      end
      if (iss && issdir != 0) m_p[issdir] <= 1'b1;
    end
  end

  function automatic void exp_rd(
    input  bit            byp,
    input  logic [AW-1:0] ra,
    output logic [DW-1:0] l,
    output logic          b
  );
    if (ra == 0) begin
      l = '0;
      b = 1'b0;
    end else if (byp && rw && dir == ra) begin
      l = din;
      b = (iss && issdir == ra) ? m_p[ra] : 1'b0;
    end else begin
      l = m_reg[ra];
      b = m_p[ra];
    end
  endfunction

  always @(negedge clk) begin
    if (live) begin
      logic [DW-1:0] el;
      logic          eb;
      int            cnt;
      for (int i = 0; i < NR; i++) begin
        exp_rd(1'b1, rd[i*AW +: AW], el, eb);
        chk($sformatf("L%0d_byp1", i), b1.L[i*DW +: DW], el);
        chk($sformatf("busy%0d_byp1", i), b1.Busy[i], eb);
        exp_rd(1'b0, rd[i*AW +: AW], el, eb);
        chk($sformatf("L%0d_byp0", i), b0.L[i*DW +: DW], el);
        chk($sformatf("busy%0d_byp0", i), b0.Busy[i], eb);
      end
      cnt = 0;
      for (int i = 0; i < 32; i++) cnt += int'(m_p[i]);
      chk("pend_byp1", b1.Pend, cnt);
      chk("pend_byp0", b0.Pend, cnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    live = 1'b0;
    rst = 1'b1; rw = 1'b0; iss = 1'b0;
    dir = '0; issdir = '0; din = '0; rd = '0;
    tick();
    rst = 1'b0;
    live = 1'b1;

    for (int i = 0; i < 32; i++) begin
      rd = {5'(31 - i), 5'(i)};
      #2;
      chk("rst_L", b1.L, 64'd0);
      chk("rst_busy", b0.Busy, 2'b00);
      chk("rst_pend", b1.Pend, 6'd0);
      tick();
    end

    rw = 1'b1; dir = 5'd5; din = 32'hDEAD_BEEF; rd = {5'd0, 5'd5};
    #2;
    chk("wr_byp1_same", b1.L[31:0], 32'hDEAD_BEEF);
    chk("wr_byp0_same", b0.L[31:0], 32'h0);
    tick();
    rw = 1'b0;
    #2;
    chk("wr_byp1_next", b1.L[31:0], 32'hDEAD_BEEF);
    chk("wr_byp0_next", b0.L[31:0], 32'hDEAD_BEEF);
    tick();

    rw = 1'b1; dir = 5'd0; din = 32'h1234;
    iss = 1'b1; issdir = 5'd0; rd = '0;
    #2;
    chk("r0_L", b1.L[31:0], 32'h0);
    chk("r0_busy", b1.Busy[0], 1'b0);
    tick();
    rw = 1'b0; iss = 1'b0;
    #2;
    chk("r0_pend", b1.Pend, 6'd0);
    chk("r0_L_after", b0.L[31:0], 32'h0);

    iss = 1'b1; issdir = 5'd7;
    tick();
    iss = 1'b0; rd = {5'd0, 5'd7};
    #2;
    chk("iss7_busy", b1.Busy[0], 1'b1);
    chk("iss7_pend", b1.Pend, 6'd1);
    tick();
    rw = 1'b1; dir = 5'd7; din = 32'd77;
    #2;
    chk("wr7_busy_byp1", b1.Busy[0], 1'b0);
    chk("wr7_busy_byp0", b0.Busy[0], 1'b1);
    chk("wr7_L_byp1", b1.L[31:0], 32'd77);
    chk("wr7_pend_hold", b1.Pend, 6'd1);
    tick();
    rw = 1'b0;
    #2;
    chk("wr7_busy_byp0_n", b0.Busy[0], 1'b0);
    chk("wr7_pend", b0.Pend, 6'd0);
    chk("wr7_L_byp0", b0.L[31:0], 32'd77);

    iss = 1'b1; issdir = 5'd7;
    tick();
    tick();
    iss = 1'b0;
    #2;
    chk("dbl_iss_pend", b1.Pend, 6'd1);
    rw = 1'b1; dir = 5'd7; din = 32'd78;
    tick();
    rw = 1'b0;
    #2;
    chk("dbl_clear_pend", b1.Pend, 6'd0);

    rw = 1'b1; dir = 5'd9; din = 32'd99;
    iss = 1'b1; issdir = 5'd9; rd = {5'd0, 5'd9};
    #2;
    chk("sim9_L_byp1", b1.L[31:0], 32'd99);
    chk("sim9_busy_byp1", b1.Busy[0], 1'b0);
    chk("sim9_L_byp0", b0.L[31:0], 32'd0);
    tick();
    rw = 1'b0; iss = 1'b0;
    #2;
    chk("sim9_L_next", b0.L[31:0], 32'd99);
    chk("sim9_busy_next", b0.Busy[0], 1'b1);
    chk("sim9_pend", b0.Pend, 6'd1);

    iss = 1'b1; issdir = 5'd3; tick();
    issdir = 5'd4; tick();
    issdir = 5'd6; tick();
    iss = 1'b0;
    #2;
    chk("mid_pend4", b1.Pend, 6'd4);
    rw = 1'b1; dir = 5'd4; din = 32'hA5;
    tick();
    rw = 1'b0; rd = {5'd6, 5'd4};
    #2;
    chk("mid_pend3", b1.Pend, 6'd3);
    chk("mid_L4", b0.L[31:0], 32'hA5);
    chk("mid_busy6", b0.Busy[1], 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #2;
    chk("mrst_pend1", b1.Pend, 6'd0);
    chk("mrst_pend0", b0.Pend, 6'd0);
    chk("mrst_busy1", b1.Busy, 2'b00);
    chk("mrst_busy0", b0.Busy, 2'b00);
    chk("mrst_L", b0.L, 64'd0);

    for (int k = 0; k < 60; k++) begin
      tick();
      rw = 1'($urandom_range(0, 1));
      dir = 5'($urandom_range(0, 31));
      din = $urandom;
      iss = 1'($urandom_range(0, 1));
      issdir = ($urandom_range(0, 3) == 0) ? dir
             : 5'($urandom_range(0, 31));
      rd = {5'($urandom_range(0, 31)), 5'($urandom_range(0, 31))};
      if ($urandom_range(0, 2) == 0) rd[4:0] = dir;
    end
    tick();
    rw = 1'b0; iss = 1'b0;
    tick();
    live = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
